// File: rtl/bram_port_arbiter_if.sv
// Client and BRAM-side signals of the two-client BRAM port arbiter.
// slave = arbiter side, master = clients plus BRAM side.
interface bram_port_arbiter_if #(
  parameter int DLEN = 32,
  parameter int HLEN = 9
);
  logic            req0, req1;
  logic            we0, we1;
  logic [HLEN-1:0] addr0, addr1;
  logic [DLEN-1:0] wdata0, wdata1;
  logic            gnt0, gnt1;
  logic            rvalid0, rvalid1;
  logic [DLEN-1:0] rdata;
  logic            bram_wen;
  logic [HLEN-1:0] bram_waddr;
  logic [DLEN-1:0] bram_din;
  logic [HLEN-1:0] bram_raddr;
  logic [DLEN-1:0] bram_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bram_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
           bram_wen, bram_waddr, bram_din, bram_raddr
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bram_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
           bram_wen, bram_waddr, bram_din, bram_raddr
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-client arbiter in front of a simple-dual-port BRAM. The read and write
// ports each run an independent round-robin; one read and one write per cycle.
module bram_port_arbiter #(
  parameter int DLEN = 32,
  parameter int HLEN = 9
) (
  input  logic               clk,
  input  logic               rst,
  bram_port_arbiter_if.slave bus
);

  logic [1:0]      req, we, wcand, rcand, wgnt, rgnt;
  logic            wprio, rprio;
  logic [1:0]      rvld_q;
  logic [HLEN-1:0] waddr_sel, raddr_sel;
  logic [DLEN-1:0] din_sel;

  // Both candidates: the pointer wins. Otherwise the lone candidate (if any).
  function automatic logic [1:0] pick(input logic [1:0] cand, input logic prio);
    pick = (cand == 2'b11) ? (prio ? 2'b10 : 2'b01) : cand;
  endfunction

  always_comb begin
    req       = {bus.req1, bus.req0};
    we        = {bus.we1, bus.we0};
    // Reset suppresses every grant, so no BRAM write can happen under reset.
    wcand     = req &  we & {2{~rst}};
    rcand     = req & ~we & {2{~rst}};
    wgnt      = pick(wcand, wprio);
    rgnt      = pick(rcand, rprio);
    waddr_sel = wgnt[1] ? bus.addr1  : bus.addr0;
    din_sel   = wgnt[1] ? bus.wdata1 : bus.wdata0;
    raddr_sel = rgnt[1] ? bus.addr1  : bus.addr0;
  end

  assign bus.gnt0       = wgnt[0] | rgnt[0];
  assign bus.gnt1       = wgnt[1] | rgnt[1];
  assign bus.bram_wen   = |wgnt;
  assign bus.bram_waddr = waddr_sel;
  assign bus.bram_din   = din_sel;
  assign bus.bram_raddr = raddr_sel;
  assign bus.rdata      = bus.bram_dout;
  // Masked by rst so a read granted just before reset is dropped immediately.
  assign bus.rvalid0    = rvld_q[0] & ~rst;
  assign bus.rvalid1    = rvld_q[1] & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wprio  <= 1'b0;
      rprio  <= 1'b0;
      rvld_q <= 2'b00;
    end else begin
      // Pointer moves to the client that was not granted.
      if (|wgnt) wprio <= wgnt[0];
      if (|rgnt) rprio <= rgnt[0];
      rvld_q <= rgnt;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed scenarios plus randomized client traffic checked against a
// behavioural model of the arbitration rules and the BRAM contents.
module tb_bram_port_arbiter;
  localparam int DLEN  = 32;
  localparam int HLEN  = 9;
  localparam int DEPTH = 2**HLEN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.DLEN(DLEN), .HLEN(HLEN)) bus();
  bram_port_arbiter #(.DLEN(DLEN), .HLEN(HLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Client drive
  logic            creq [2];
  logic            cwe  [2];
  logic [HLEN-1:0] caddr[2];
  logic [DLEN-1:0] cwd  [2];
  assign bus.req0 = creq[0];  assign bus.req1 = creq[1];
  assign bus.we0  = cwe[0];   assign bus.we1  = cwe[1];
  assign bus.addr0 = caddr[0]; assign bus.addr1 = caddr[1];
  assign bus.wdata0 = cwd[0]; assign bus.wdata1 = cwd[1];

  // BRAM instance model: registered read, read-old on collision
  logic [DLEN-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= '0;
    end else if (bus.bram_wen) begin
      bram[bus.bram_waddr] <= bus.bram_din;
    end
    bus.bram_dout <= bram[bus.bram_raddr];
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int              wp = 0, rp = 0;
  bit              erv[2];
  logic [DLEN-1:0] erdata;
  logic [DLEN-1:0] ref_mem[DEPTH];

  // Observations from the last step, for directed checks
  logic [1:0]      obs_gnt, obs_rv;
  logic            obs_wen;
  logic [HLEN-1:0] obs_waddr, obs_raddr;
  logic [DLEN-1:0] obs_rdata;

  task automatic set_cli(input int k, input bit r, input bit w, input int a, input logic [DLEN-1:0] d);
    creq[k] = r; cwe[k] = w; caddr[k] = HLEN'(a); cwd[k] = d;
  endtask

  // One clock cycle: called just after a posedge with inputs already driven.
  task automatic step(input bit r);
    bit wc[2], rc[2];
    int wg, rg;
    rst = r;
    @(negedge clk);
    wg = -1; rg = -1;
    for (int k = 0; k < 2; k++) begin
      wc[k] = creq[k] &&  cwe[k] && !r;
      rc[k] = creq[k] && !cwe[k] && !r;
    end
    if (wc[0] && wc[1]) wg = wp; else if (wc[0]) wg = 0; else if (wc[1]) wg = 1;
    if (rc[0] && rc[1]) rg = rp; else if (rc[0]) rg = 0; else if (rc[1]) rg = 1;

    obs_gnt = {bus.gnt1, bus.gnt0};   obs_wen = bus.bram_wen;
    obs_waddr = bus.bram_waddr;       obs_raddr = bus.bram_raddr;
    obs_rv = {bus.rvalid1, bus.rvalid0}; obs_rdata = bus.rdata;

    chk("gnt0", bus.gnt0, 64'((wg == 0) || (rg == 0)));
    chk("gnt1", bus.gnt1, 64'((wg == 1) || (rg == 1)));
    chk("wen",  bus.bram_wen, 64'(wg >= 0));
    if (wg >= 0) begin
      chk("waddr", bus.bram_waddr, 64'(caddr[wg]));
      chk("din",   bus.bram_din,   64'(cwd[wg]));
    end
    if (rg >= 0) chk("raddr", bus.bram_raddr, 64'(caddr[rg]));
    chk("rvalid0", bus.rvalid0, 64'(erv[0] && !r));
    chk("rvalid1", bus.rvalid1, 64'(erv[1] && !r));
    if ((erv[0] || erv[1]) && !r) chk("rdata", bus.rdata, 64'(erdata));

    if (r) begin
      wp = 0; rp = 0; erv[0] = 0; erv[1] = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      erv[0] = (rg == 0); erv[1] = (rg == 1);
      if (rg >= 0) begin erdata = ref_mem[caddr[rg]]; rp = 1 - rg; end
      if (wg >= 0) begin ref_mem[caddr[wg]] = cwd[wg]; wp = 1 - wg; end
    end
    @(posedge clk); #1;
    if (wg >= 0) creq[wg] = 1'b0;
    if (rg >= 0) creq[rg] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) set_cli(k, 0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    erv[0] = 0; erv[1] = 0; erdata = '0;
    #1;

    // 1 Reset blocks all grants and writes
    set_cli(0, 1, 1, 4, 32'h11); set_cli(1, 1, 1, 6, 32'h22);
    step(1); step(1);
    chk("t1_gnt", obs_gnt, 0);
    chk("t1_wen", obs_wen, 0);
    creq[0] = 0; creq[1] = 0;
    step(0);
    chk("t1_rv", obs_rv, 0);

    // 2 Solo write then read-back one cycle after grant
    set_cli(0, 1, 1, 5, 32'h0000_1234); step(0);
    chk("t2_wen", obs_wen, 1);
    chk("t2_waddr", obs_waddr, 5);
    set_cli(0, 1, 0, 5, '0); step(0);
    chk("t2_gnt", obs_gnt, 2'b01);
    step(0);
    chk("t2_rv", obs_rv, 2'b01);
    chk("t2_rdata", obs_rdata, 32'h0000_1234);

    // 3 Write contention from reset alternates 0,1,0,1
    step(1);
    for (int c = 0; c < 4; c++) begin
      set_cli(0, 1, 1, 1, 32'(100 + c)); set_cli(1, 1, 1, 2, 32'(200 + c));
      step(0);
      chk("t3_gnt", obs_gnt, (c % 2 == 0) ? 2'b01 : 2'b10);
      chk("t3_wen", obs_wen, 1);
    end
    creq[0] = 0; creq[1] = 0;

    // 4 Read and write granted in parallel
    set_cli(0, 1, 0, 7, '0); set_cli(1, 1, 1, 9, 32'h99); step(0);
    chk("t4_gnt", obs_gnt, 2'b11);
    chk("t4_wen", obs_wen, 1);
    chk("t4_raddr", obs_raddr, 7);
    step(0);
    chk("t4_rv", obs_rv, 2'b01);

    // 5 Read-during-write returns the old word
    set_cli(0, 1, 1, 3, 32'hA); step(0);
    set_cli(1, 1, 1, 3, 32'hB); set_cli(0, 1, 0, 3, '0); step(0);
    set_cli(0, 1, 0, 3, '0); step(0);
    chk("t5_rv_old", obs_rv, 2'b01);
    chk("t5_old", obs_rdata, 32'hA);
    step(0);
    chk("t5_new", obs_rdata, 32'hB);

    // 6 Reset right after a read grant drops the data and clears pointers
    set_cli(0, 1, 0, 10, '0); step(0);
    step(1);
    chk("t6_rv", obs_rv, 0);
    set_cli(0, 1, 1, 20, 32'h5); set_cli(1, 1, 1, 21, 32'h6); step(0);
    chk("t6_gnt", obs_gnt, 2'b01);
    creq[1] = 0;

    // Randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++)
        if (!creq[k] && ($urandom % 4 != 0))
          set_cli(k, 1, $urandom % 2, $urandom % 16, $urandom);
      step(($urandom % 200) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
